// File: rtl/alu_pkg.sv
// Purpose: shared ALU function codes, MIPS opcode/funct values and ID/EX stage record.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // ALU Func: bit 3 inverts In2 and sets carry-in, bits [2:0] select the operation.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_XNOR = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Contents of the ID/EX output register.
    typedef struct packed {
        logic        valid;
        logic [3:0]  func;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  wr_reg;
        logic        wr_en;
        logic        illegal;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        valid:   1'b0,
        func:    ALU_ADD,
        in1:     32'd0,
        in2:     32'd0,
        wr_reg:  5'd0,
        wr_en:   1'b0,
        illegal: 1'b0
    };

endpackage

// File: rtl/alu_decode.sv
// Purpose: decode a MIPS-style instruction into ALU Func, operands and writeback target.
// Latency: purely combinational.
// Backpressure: none; the owning stage decides when the result is captured.
// Ports: instr/rs_data/rt_data in; func, in1, in2, wr_reg, wr_en, illegal out.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  func,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  wr_reg,
    output logic        wr_en,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_fields;

    assign opcode   = instr[31:26];
    assign rt_idx   = instr[20:16];
    assign rd_idx   = instr[15:11];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    // rs index and shamt are not needed: rs data arrives already read.
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        func    = ALU_ADD;
        in1     = rs_data;
        in2     = rt_data;
        wr_reg  = 5'd0;
        wr_en   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_reg = rd_idx;
                wr_en  = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: func = ALU_ADD;
                    FN_SUB, FN_SUBU: func = ALU_SUB;
                    FN_AND:          func = ALU_AND;
                    FN_OR:           func = ALU_OR;
                    FN_XOR:          func = ALU_XOR;
                    FN_SLT:          func = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        wr_reg  = 5'd0;
                        wr_en   = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                in2 = imm_sext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_SLTI: begin
                func = ALU_SLT; in2 = imm_sext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_ANDI: begin
                func = ALU_AND; in2 = imm_zext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_ORI: begin
                func = ALU_OR; in2 = imm_zext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_XORI: begin
                func = ALU_XOR; in2 = imm_zext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_LW: begin
                in2 = imm_sext; wr_reg = rt_idx; wr_en = 1'b1;
            end
            OP_SW: begin
                // Address computation only; the store does not write the register file.
                in2 = imm_sext; wr_reg = rt_idx;
            end
            OP_BEQ, OP_BNE: begin
                // Compare by subtraction; rt data stays on In2.
                func = ALU_SUB;
            end
            default: illegal = 1'b1;
        endcase
        // r0 is hardwired to zero, so a write to it is dropped.
        if (wr_reg == 5'd0) begin
            wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Purpose: ID/EX pipeline register feeding the ALU with decoded Func/In1/In2.
// Latency: one cycle from capture edge to outputs.
// Backpressure: stall holds the register and drops in_ready; flush loads a bubble and overrides stall.
// Ports: clk, rst (async high); in_valid/in_instr/in_rs_data/in_rt_data, stall, flush in;
//        in_ready, out_valid, out_func, out_in1, out_in2, out_wr_reg, out_wr_en, out_illegal out.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs_data,
    input  logic [XLEN-1:0] in_rt_data,
    input  logic            stall,
    input  logic            flush,
    output logic            in_ready,
    output logic            out_valid,
    output logic [3:0]      out_func,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [4:0]      out_wr_reg,
    output logic            out_wr_en,
    output logic            out_illegal
);

    stage_t dec;
    stage_t stage_q;

    alu_decode u_decode (
        .instr   (in_instr),
        .rs_data (in_rs_data),
        .rt_data (in_rt_data),
        .func    (dec.func),
        .in1     (dec.in1),
        .in2     (dec.in2),
        .wr_reg  (dec.wr_reg),
        .wr_en   (dec.wr_en),
        .illegal (dec.illegal)
    );

    // Illegal instructions still travel as valid so the next stage can trap on them.
    assign dec.valid = 1'b1;

    assign in_ready = !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= STAGE_BUBBLE;
        end else if (flush) begin
            stage_q <= STAGE_BUBBLE;
        end else if (!stall) begin
            stage_q <= in_valid ? dec : STAGE_BUBBLE;
        end
    end

    assign out_valid   = stage_q.valid;
    assign out_func    = stage_q.func;
    assign out_in1     = stage_q.in1;
    assign out_in2     = stage_q.in2;
    assign out_wr_reg  = stage_q.wr_reg;
    assign out_wr_en   = stage_q.wr_en;
    assign out_illegal = stage_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Purpose: self-checking bench for alu_ctrl_stage against a table-driven reference model.
// Latency: expects decoded results one clock after capture.
// Backpressure: exercises stall hold, flush override and back-to-back acceptance.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_func;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [4:0]  out_wr_reg;
    logic        out_wr_en;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    // Output vector layout: {valid, func, in1, in2, wr_reg, wr_en, illegal}
    logic [75:0] obs;
    logic [75:0] exp_v;
    logic [75:0] exp_m;
    localparam logic [75:0] BUB_V = {1'b0, 4'b0100, 71'd0};
    localparam logic [75:0] ALL_M = {76{1'b1}};

    assign obs = {out_valid, out_func, out_in1, out_in2, out_wr_reg, out_wr_en, out_illegal};

    alu_ctrl_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .stall       (stall),
        .flush       (flush),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_func    (out_func),
        .out_in1     (out_in1),
        .out_in2     (out_in2),
        .out_wr_reg  (out_wr_reg),
        .out_wr_en   (out_wr_en),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference: instruction table from the ISA description. Fields that the ISA leaves
    // undefined (operands/target of illegal ops, target of branches) are masked out.
    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                              output logic [75:0] v, output logic [75:0] m);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        logic        ok;
        logic [3:0]  f;
        logic [31:0] b;
        logic [4:0]  d;
        logic        we;
        logic        dmask;
        op = ins[31:26]; fn = ins[5:0];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        ok = 1'b1; f = 4'b0100; b = rt; d = 5'd0; we = 1'b0; dmask = 1'b1;
        if (op == 6'h00) begin
            d = ins[15:11]; we = 1'b1;
            case (fn)
                6'h20, 6'h21: f = 4'b0100;
                6'h22, 6'h23: f = 4'b1100;
                6'h24:        f = 4'b0000;
                6'h25:        f = 4'b0001;
                6'h26:        f = 4'b0010;
                6'h2A:        f = 4'b1101;
                default:      ok = 1'b0;
            endcase
        end else begin
            d = ins[20:16]; we = 1'b1;
            case (op)
                6'h08, 6'h09: begin f = 4'b0100; b = sx; end
                6'h0A:        begin f = 4'b1101; b = sx; end
                6'h0C:        begin f = 4'b0000; b = zx; end
                6'h0D:        begin f = 4'b0001; b = zx; end
                6'h0E:        begin f = 4'b0010; b = zx; end
                6'h23:        begin f = 4'b0100; b = sx; end
                6'h2B:        begin f = 4'b0100; b = sx; we = 1'b0; end
                6'h04, 6'h05: begin f = 4'b1100; we = 1'b0; dmask = 1'b0; end
                default:      ok = 1'b0;
            endcase
        end
        if (!ok) begin f = 4'b0100; we = 1'b0; end
        if (d == 5'd0) we = 1'b0;
        v = {1'b1, f, rs, b, d, we, !ok};
        m = {5'h1F, ok ? 32'hFFFF_FFFF : 32'h0, ok ? 32'hFFFF_FFFF : 32'h0,
             (ok && dmask) ? 5'h1F : 5'h00, 2'b11};
    endtask

    // Advance one clock, updating the expected register from the edge rules.
    task automatic tick();
        logic [75:0] dv, dm, nv, nm;
        ref_decode(in_instr, in_rs_data, in_rt_data, dv, dm);
        if (flush)         begin nv = BUB_V; nm = ALL_M; end
        else if (stall)    begin nv = exp_v; nm = exp_m; end
        else if (in_valid) begin nv = dv;    nm = dm;    end
        else               begin nv = BUB_V; nm = ALL_M; end
        @(posedge clk);
        #1;
        exp_v = nv;
        exp_m = nm;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic st, input logic fl);
        in_valid = v; in_instr = ins; in_rs_data = rs; in_rt_data = rt; stall = st; flush = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== BUB_V) begin
            errors++; $display("FAIL reset_init got=%h want=%h", obs, BUB_V);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_v = BUB_V; exp_m = ALL_M;
        // Load a real instruction, then hit reset in the middle of a stall.
        drive(1'b1, mk_r(5'd1, 5'd2, 5'd9, 6'h20), 32'h1234, 32'h55, 1'b0, 1'b0);
        tick();
        checks++;
        if ((obs & exp_m) !== (exp_v & exp_m)) begin
            errors++; $display("FAIL reset_preload got=%h want=%h", obs & exp_m, exp_v & exp_m);
        end
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== BUB_V) begin
            errors++; $display("FAIL reset_midstall got=%h want=%h", obs, BUB_V);
        end
        exp_v = BUB_V; exp_m = ALL_M;
        #2;
        rst = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_rtype_sub();
        drive(1'b1, mk_r(5'd4, 5'd6, 5'd3, 6'h22), 32'd7, 32'd5, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs !== {1'b1, 4'b1100, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rtype_sub got=%h want=%h", obs,
                               {1'b1, 4'b1100, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_itype_ext();
        drive(1'b1, mk_i(6'h08, 5'd1, 5'd7, 16'hFFFF), 32'd10, 32'd99, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_in2 !== 32'hFFFF_FFFF || out_func !== 4'b0100) begin
            errors++; $display("FAIL addi_sext got in2=%h func=%b want in2=ffffffff func=0100",
                               out_in2, out_func);
        end
        drive(1'b1, mk_i(6'h0C, 5'd1, 5'd7, 16'hFFFF), 32'd10, 32'd99, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_in2 !== 32'h0000_FFFF || out_func !== 4'b0000) begin
            errors++; $display("FAIL andi_zext got in2=%h func=%b want in2=0000ffff func=0000",
                               out_in2, out_func);
        end
        checks++;
        if ((obs & exp_m) !== (exp_v & exp_m)) begin
            errors++; $display("FAIL andi_model got=%h want=%h", obs & exp_m, exp_v & exp_m);
        end
    endtask

    task automatic test_stall_flush();
        logic [75:0] held;
        drive(1'b1, mk_r(5'd2, 5'd3, 5'd8, 6'h20), 32'hA5A5_0001, 32'h0000_0F0F, 1'b0, 1'b0);
        tick();
        held = obs;
        checks++;
        if ((obs & exp_m) !== (exp_v & exp_m)) begin
            errors++; $display("FAIL stall_load got=%h want=%h", obs & exp_m, exp_v & exp_m);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk_r(5'd2, 5'd3, 5'd9, 6'h24), $urandom, $urandom, 1'b1, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, in_ready);
            end
            tick();
            checks++;
            if (obs !== held || (obs & exp_m) !== (exp_v & exp_m)) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, obs, held);
            end
        end
        drive(1'b1, mk_r(5'd2, 5'd3, 5'd9, 6'h24), 32'd1, 32'd2, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got=%b want=0", in_ready);
        end
        tick();
        checks++;
        if (obs !== BUB_V) begin
            errors++; $display("FAIL flush_bubble got=%h want=%h", obs, BUB_V);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_release got=%b want=1", in_ready);
        end
    endtask

    task automatic test_illegal_zero();
        drive(1'b1, mk_r(5'd1, 5'd2, 5'd5, 6'h27), 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_illegal !== 1'b1 || out_wr_en !== 1'b0 || out_valid !== 1'b1 || out_func !== 4'b0100) begin
            errors++; $display("FAIL illegal_nor got ill=%b we=%b vld=%b func=%b want 1 0 1 0100",
                               out_illegal, out_wr_en, out_valid, out_func);
        end
        drive(1'b1, mk_r(5'd1, 5'd2, 5'd0, 6'h20), 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_wr_en !== 1'b0 || (obs & exp_m) !== (exp_v & exp_m)) begin
            errors++; $display("FAIL add_rd0 got=%h want=%h", obs & exp_m, exp_v & exp_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns [4];
        logic [3:0] fus [4];
        fns[0] = 6'h24; fns[1] = 6'h25; fns[2] = 6'h26; fns[3] = 6'h2A;
        fus[0] = 4'b0000; fus[1] = 4'b0001; fus[2] = 4'b0010; fus[3] = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk_r(5'd1, 5'd2, 5'(10 + i), fns[i]), $urandom, $urandom, 1'b0, 1'b0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_func !== fus[i] || (obs & exp_m) !== (exp_v & exp_m)) begin
                errors++; $display("FAIL b2b_%0d got vld=%b func=%b want vld=1 func=%b",
                                   i, out_valid, out_func, fus[i]);
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [12];
        logic [5:0]  fns [10];
        logic [31:0] r;
        ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h27, 6'h00};
        r = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            r[31:26] = ops[$urandom_range(0, 11)];
            r[5:0]   = fns[$urandom_range(0, 9)];
        end
        return r;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (in_ready !== !stall) begin
                errors++; $display("FAIL rand_ready i=%0d got=%b want=%b", i, in_ready, !stall);
            end
            tick();
            checks++;
            if ((obs & exp_m) !== (exp_v & exp_m)) begin
                errors++; $display("FAIL rand_out i=%0d got=%h want=%h", i, obs & exp_m, exp_v & exp_m);
            end
        end
    endtask

    initial begin
        exp_v = BUB_V;
        exp_m = ALL_M;
        test_reset();
        test_rtype_sub();
        test_itype_ext();
        test_stall_flush();
        test_illegal_zero();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ID/EX control stage that feeds the ALU. Decodes a 32-bit MIPS-style instruction into the ALU's 4-bit function code and selects and extends the operands. Holds the result in a pipeline register with valid, stall and flush control. It sits between register-file read and the ALU, and produces exactly the Func/In1/In2 encoding the ALU consumes.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the ID stage presents a valid instruction.
- `in_instr`  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- `in_rs_data`  in  32  register-file read of rs.
- `in_rt_data`  in  32  register-file read of rt.
- `stall`  in  1  hold the current output register unchanged.
- `flush`  in  1  replace the next output with a bubble.
- `in_ready`  out  1  equals `!stall`; the ID stage advances only when it is 1.
- `out_valid`  out  1  the output register holds a real instruction.
- `out_func`  out  4  ALU Func: bit 3 inverts In2 and sets carry-in; bits [2:0] are 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 ADD, 101 SLT.
- `out_in1`  out  32  ALU In1 (rs data).
- `out_in2`  out  32  ALU In2 (rt data or extended immediate).
- `out_wr_reg`  out  5  destination register.
- `out_wr_en`  out  1  register writeback enable.
- `out_illegal`  out  1  the captured instruction was undecodable.

## Operation
R-type (opcode 0x00), decoded by funct:
- 0x20/0x21 → 0100 (ADD)
- 0x22/0x23 → 1100 (SUB)
- 0x24 → 0000 (AND)
- 0x25 → 0001 (OR)
- 0x26 → 0010 (XOR)
- 0x2A → 1101 (SLT)
- For all of these: In2 = rt data, wr_reg = rd, wr_en = 1.

I-type, with In2 = extended immediate and wr_reg = rt:
- addi 0x08 / addiu 0x09 → 0100, sign-extended.
- slti 0x0A → 1101, sign-extended.
- andi 0x0C → 0000, zero-extended.
- ori 0x0D → 0001, zero-extended.
- xori 0x0E → 0010, zero-extended.
- lw 0x23 → 0100, sign-extended, wr_en = 1.
- sw 0x2B → 0100, sign-extended, wr_en = 0.

Branch:
- beq 0x04 / bne 0x05 → 1100, In2 = rt data, wr_en = 0.

Illegal and special cases:
- Any other opcode/funct, including nor 0x27 → illegal = 1, func = 0100, wr_en = 0. `out_valid` still follows `in_valid`.
- wr_reg == 0 forces wr_en = 0.

Bubble contents: out_valid = 0, wr_en = 0, illegal = 0, func = 0100, in1/in2/wr_reg = 0.

## Timing
- Reset (async, any cycle, including mid-stall): all outputs are zero except out_func = 4'b0100. Release takes effect at the next edge.
- Latency: the register captures decoded inputs at the edge and presents them one cycle later.
- Edge priority:
  - `flush` wins: bubble loaded, regardless of stall or in_valid.
  - Otherwise, `stall`: all output registers hold.
  - Otherwise, `in_valid` = 1: decoded instruction loaded.
  - Otherwise: bubble loaded.
- `in_ready` is combinational from `stall` only; it has no dependence on flush.
- Back-to-back valid instructions are accepted every cycle with no bubbles inserted.
- Outputs change only on the clock edge or on reset; there are no combinational input-to-output paths except `in_ready`.

## Structure
- Shared package `alu_pkg` holds:
  - Func constants: `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_XNOR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
  - Opcode and funct constants.
  - Bubble default values.
- One combinational sub-module, `alu_decode`:
  - Inputs: instr, rs data, rt data.
  - Outputs: func, in1, in2, wr_reg, wr_en, illegal.
- `alu_ctrl_stage` instantiates `alu_decode` and implements only the priority register.

## Test plan
- **Reset:** assert rst mid-stream → within the same cycle out_valid = 0, out_func = 0100, all other outputs 0.
- **R-type SUB:** sub rd=3 with rs_data = 7, rt_data = 5 → next cycle out_func = 1100, in1 = 7, in2 = 5, wr_reg = 3, wr_en = 1, valid = 1.
- **I-type extension:**
  - addi imm = 0xFFFF → in2 = 0xFFFFFFFF, func = 0100.
  - andi imm = 0xFFFF → in2 = 0x0000FFFF, func = 0000.
- **Stall then flush:**
  - valid add, then 3 stall cycles → outputs held for 3 cycles and in_ready = 0.
  - flush together with stall → bubble next cycle.
- **Illegal and zero destination:**
  - funct 0x27 → illegal = 1, wr_en = 0, valid = 1.
  - add with rd = 0 → wr_en = 0.
- **Throughput:** 4 consecutive valid instructions (and, or, xor, slt) → 4 consecutive outputs with func 0000, 0001, 0010, 1101 and no bubbles.
